// File: rtl/mem_wb.sv
// Memory-access stage and MEM/WB pipeline register: runs loads/stores over a
// req/ack data-memory handshake, stalls upstream while busy, registers write-back.
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResult,
  input  logic [15:0] r15Result,
  input  logic [15:0] op2Val,
  input  logic [3:0]  destReg,
  input  logic        wb,
  input  logic        r15We,
  input  logic        memRd,
  input  logic        memWr,
  output logic        dmReq,
  output logic        dmWe,
  output logic [15:0] dmAddr,
  output logic [15:0] dmWData,
  input  logic        dmAck,
  input  logic [15:0] dmRData,
  output logic        stall,
  output logic        wbEn,
  output logic [3:0]  wbReg,
  output logic [15:0] wbData,
  output logic        wbR15En,
  output logic [15:0] wbR15Data
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic        dm_we_q, dm_we_d;
  logic [15:0] dm_addr_q, dm_addr_d;
  logic [15:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  cap_dest_q, cap_dest_d;
  logic        cap_wb_q, cap_wb_d;
  logic        cap_r15we_q, cap_r15we_d;
  logic [15:0] cap_r15_q, cap_r15_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_reg_q, wb_reg_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        wb_r15_en_q, wb_r15_en_d;
  logic [15:0] wb_r15_data_q, wb_r15_data_d;

  always_comb begin
    state_d       = state_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    cap_dest_d    = cap_dest_q;
    cap_wb_d      = cap_wb_q;
    cap_r15we_d   = cap_r15we_q;
    cap_r15_d     = cap_r15_q;
    // Enables are single-cycle pulses; data fields hold unless reloaded.
    wb_en_d       = 1'b0;
    wb_reg_d      = wb_reg_q;
    wb_data_d     = wb_data_q;
    wb_r15_en_d   = 1'b0;
    wb_r15_data_d = wb_r15_data_q;

    if (state_q == IDLE) begin
      if (memRd || memWr) begin
        state_d     = ACCESS;
        dm_we_d     = memWr;
        dm_addr_d   = aluResult;
        dm_wdata_d  = op2Val;
        cap_dest_d  = destReg;
        cap_wb_d    = wb;
        cap_r15we_d = r15We;
        cap_r15_d   = r15Result;
      end else begin
        wb_en_d       = wb;
        wb_reg_d      = destReg;
        wb_data_d     = aluResult;
        wb_r15_en_d   = r15We;
        wb_r15_data_d = r15Result;
      end
    end else if (dmAck) begin
      state_d       = IDLE;
      // A store (including memRd && memWr) never writes the register file.
      wb_en_d       = cap_wb_q & ~dm_we_q;
      wb_reg_d      = cap_dest_q;
      if (!dm_we_q) wb_data_d = dmRData;
      wb_r15_en_d   = cap_r15we_q;
      wb_r15_data_d = cap_r15_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      cap_dest_q    <= '0;
      cap_wb_q      <= 1'b0;
      cap_r15we_q   <= 1'b0;
      cap_r15_q     <= '0;
      wb_en_q       <= 1'b0;
      wb_reg_q      <= '0;
      wb_data_q     <= '0;
      wb_r15_en_q   <= 1'b0;
      wb_r15_data_q <= '0;
    end else begin
      state_q       <= state_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      cap_dest_q    <= cap_dest_d;
      cap_wb_q      <= cap_wb_d;
      cap_r15we_q   <= cap_r15we_d;
      cap_r15_q     <= cap_r15_d;
      wb_en_q       <= wb_en_d;
      wb_reg_q      <= wb_reg_d;
      wb_data_q     <= wb_data_d;
      wb_r15_en_q   <= wb_r15_en_d;
      wb_r15_data_q <= wb_r15_data_d;
    end
  end

  assign stall     = (state_q == ACCESS);
  assign dmReq     = (state_q == ACCESS);
  assign dmWe      = dm_we_q;
  assign dmAddr    = dm_addr_q;
  assign dmWData   = dm_wdata_q;
  assign wbEn      = wb_en_q;
  assign wbReg     = wb_reg_q;
  assign wbData    = wb_data_q;
  assign wbR15En   = wb_r15_en_q;
  assign wbR15Data = wb_r15_data_q;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: instruction-level model with program-ordered memory and a
// separate memory device answering the handshake with random latency.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] aluResult = '0, r15Result = '0, op2Val = '0;
  logic [3:0]  destReg = '0;
  logic        wb = 1'b0, r15We = 1'b0, memRd = 1'b0, memWr = 1'b0;
  logic        dmReq, dmWe;
  logic [15:0] dmAddr, dmWData;
  logic        dmAck = 1'b0;
  logic [15:0] dmRData = '0;
  logic        stall, wbEn;
  logic [3:0]  wbReg;
  logic [15:0] wbData;
  logic        wbR15En;
  logic [15:0] wbR15Data;

  mem_wb dut (
    .clk(clk), .rst(rst), .aluResult(aluResult), .r15Result(r15Result),
    .op2Val(op2Val), .destReg(destReg), .wb(wb), .r15We(r15We),
    .memRd(memRd), .memWr(memWr), .dmReq(dmReq), .dmWe(dmWe),
    .dmAddr(dmAddr), .dmWData(dmWData), .dmAck(dmAck), .dmRData(dmRData),
    .stall(stall), .wbEn(wbEn), .wbReg(wbReg), .wbData(wbData),
    .wbR15En(wbR15En), .wbR15Data(wbR15Data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu, r15, op2;
    logic [3:0]  dest;
    logic        wb, r15we, rd, wr;
    int          delay;
  } instr_t;

  instr_t      instr_q[$];
  instr_t      cur, nxt;
  bit          nxt_valid = 0, m_out = 0, rnd_mode = 0;
  int          wait_cnt = 0;
  logic [15:0] model_mem[16];
  logic [15:0] dev_mem[16];
  logic [15:0] cur_ld;
  bit          exp_en = 0, exp_r15en = 0;
  logic [3:0]  exp_reg;
  logic [15:0] exp_data, exp_r15data;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic instr_t mk(input logic [15:0] alu, input logic [3:0] dest,
                                input logic w, input logic rd, input logic wr,
                                input logic [15:0] op2, input logic r15we,
                                input logic [15:0] r15, input int delay);
    instr_t i;
    i.alu = alu; i.dest = dest; i.wb = w; i.rd = rd; i.wr = wr;
    i.op2 = op2; i.r15we = r15we; i.r15 = r15; i.delay = delay;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int kind;
    kind    = $urandom_range(0, 3);
    i.alu   = 16'($urandom);
    i.r15   = 16'($urandom);
    i.op2   = 16'($urandom);
    i.dest  = 4'($urandom);
    i.wb    = 1'($urandom);
    i.r15we = 1'($urandom);
    i.wr    = (kind == 3);
    i.rd    = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
    i.delay = -1;
    return i;
  endfunction

  function automatic instr_t fetch();
    if (instr_q.size() > 0) return instr_q.pop_front();
    if (rnd_mode) return rand_instr();
    return mk('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, -1);
  endfunction

  task automatic drive(input instr_t i);
    aluResult = i.alu; r15Result = i.r15; op2Val = i.op2; destReg = i.dest;
    wb = i.wb; r15We = i.r15we; memRd = i.rd; memWr = i.wr;
  endtask

  // One cycle: check what the last edge produced, then set up the next edge.
  task automatic step();
    @(negedge clk);
    chk("stall", stall, m_out);
    chk("dmReq", dmReq, m_out);
    chk("wbEn", wbEn, exp_en);
    if (exp_en) begin
      chk("wbReg", wbReg, exp_reg);
      chk("wbData", wbData, exp_data);
    end
    chk("wbR15En", wbR15En, exp_r15en);
    if (exp_r15en) chk("wbR15Data", wbR15Data, exp_r15data);
    if (m_out) begin
      chk("dmAddr", dmAddr, cur.alu);
      chk("dmWe", dmWe, cur.wr);
      if (cur.wr) chk("dmWData", dmWData, cur.op2);
    end
    exp_en = 0;
    exp_r15en = 0;
    if (m_out) begin
      if (!nxt_valid) begin nxt = fetch(); nxt_valid = 1; end
      drive(nxt);
      if (wait_cnt == 0) begin
        dmAck = 1'b1;
        dmRData = 16'($urandom);
        if (dmWe) dev_mem[dmAddr[3:0]] = dmWData;
        else dmRData = dev_mem[dmAddr[3:0]];
        if (!cur.wr) begin exp_en = cur.wb; exp_reg = cur.dest; exp_data = cur_ld; end
        exp_r15en = cur.r15we;
        exp_r15data = cur.r15;
        m_out = 0;
      end else begin
        dmAck = 1'b0;
        dmRData = 16'($urandom);
        wait_cnt--;
      end
    end else begin
      if (!nxt_valid) nxt = fetch();
      nxt_valid = 0;
      drive(nxt);
      dmAck = 1'($urandom);
      dmRData = 16'($urandom);
      if (nxt.rd || nxt.wr) begin
        cur = nxt;
        if (nxt.wr) model_mem[nxt.alu[3:0]] = nxt.op2;
        else cur_ld = model_mem[nxt.alu[3:0]];
        m_out = 1;
        wait_cnt = (nxt.delay >= 0) ? nxt.delay : $urandom_range(0, 3);
      end else begin
        exp_en = nxt.wb; exp_reg = nxt.dest; exp_data = nxt.alu;
        exp_r15en = nxt.r15we; exp_r15data = nxt.r15;
      end
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_dmReq"}, dmReq, 0);     chk({pfx, "_dmWe"}, dmWe, 0);
    chk({pfx, "_dmAddr"}, dmAddr, 0);   chk({pfx, "_dmWData"}, dmWData, 0);
    chk({pfx, "_stall"}, stall, 0);     chk({pfx, "_wbEn"}, wbEn, 0);
    chk({pfx, "_wbReg"}, wbReg, 0);     chk({pfx, "_wbData"}, wbData, 0);
    chk({pfx, "_wbR15En"}, wbR15En, 0); chk({pfx, "_wbR15Data"}, wbR15Data, 0);
  endtask

  task automatic run_queue();
    for (int g = 0; g < 400 && instr_q.size() > 0; g++) step();
    chk("queue_drained", 16'(instr_q.size()), 0);
    repeat (6) step();
  endtask

  task automatic model_reset();
    m_out = 0; nxt_valid = 0; exp_en = 0; exp_r15en = 0; dmAck = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      model_mem[a] = 16'($urandom);
      dev_mem[a] = model_mem[a];
    end
    model_mem[0] = 16'hBEEF; dev_mem[0] = 16'hBEEF;

    #3 rst = 1'b0;
    #1 chk_all_zero("rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Directed sequences; the model checks timing and values cycle by cycle.
    instr_q.push_back(mk(16'h1234, 4'd3, 1, 0, 0, '0, 0, '0, -1));
    instr_q.push_back(mk(16'h0040, 4'd5, 1, 1, 0, '0, 0, '0, 2));
    instr_q.push_back(mk(16'h0010, 4'd6, 1, 0, 1, 16'h00FF, 0, '0, 0));
    instr_q.push_back(mk(16'h0023, 4'd7, 1, 1, 0, '0, 0, '0, 1));
    instr_q.push_back(mk(16'h0007, 4'd2, 1, 0, 0, '0, 0, '0, -1));
    instr_q.push_back(mk(16'h0010, 4'd8, 1, 1, 0, '0, 0, '0, 0));
    instr_q.push_back(mk(16'h0023, 4'd9, 1, 1, 0, '0, 1, 16'h5A5A, 0));
    instr_q.push_back(mk(16'h0031, 4'd1, 1, 1, 1, 16'hC0DE, 0, '0, 1));
    instr_q.push_back(mk(16'h0031, 4'd4, 1, 1, 0, '0, 0, '0, 0));
    instr_q.push_back(mk(16'h0000, 4'd0, 0, 0, 0, '0, 1, 16'hA5A5, -1));
    run_queue();

    // Reset in the middle of a long access abandons it immediately.
    instr_q.push_back(mk(16'h0042, 4'd5, 1, 1, 0, '0, 0, '0, 20));
    for (int g = 0; g < 10 && !m_out; g++) step();
    step();
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    instr_q.push_back(mk(16'h1234, 4'd3, 1, 0, 0, '0, 0, '0, -1));
    run_queue();

    rnd_mode = 1;
    repeat (3000) step();
    rnd_mode = 0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
